// File: rtl/mem_mode_pkg.sv
// Access-mode encodings shared by the processor memory port and everything that drives it.
// MODE_NONE idles the port; the sized modes select byte/half/word transfers.
package mem_mode_pkg;

    localparam logic [2:0] MODE_NONE = 3'd0;
    localparam logic [2:0] MODE_BYTE = 3'd1;
    localparam logic [2:0] MODE_HALF = 3'd2;
    localparam logic [2:0] MODE_WORD = 3'd3;

endpackage

// File: rtl/serial_memory_loader_pkg.sv
// Command/response bytes and FSM states for the serial memory loader.
// Memory mode encodings come from mem_mode_pkg; consumers import both packages.
package loader_pkg;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_P = 8'h50;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_E = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        WRITE,
        READ_WAIT,
        SEND,
        SEND_WAIT
    } loaderState_t;

endpackage

// File: rtl/serial_memory_loader_if.sv
// Processor external-memory port as seen by the loader (master) and the core/memory (slave).
// Plain level signals, no handshake: the loader owns the port while externalMemoryControl is high.
interface serial_memory_loader_if;

    logic        pause;
    logic        externalMemoryControl;
    logic [31:0] externalAddress;
    logic [31:0] externalData;
    logic [2:0]  externalReadMode;
    logic [2:0]  externalWriteMode;
    logic [31:0] externalDataIn;

    modport master (
        output pause,
        output externalMemoryControl,
        output externalAddress,
        output externalData,
        output externalReadMode,
        output externalWriteMode,
        input  externalDataIn
    );

    modport slave (
        input  pause,
        input  externalMemoryControl,
        input  externalAddress,
        input  externalData,
        input  externalReadMode,
        input  externalWriteMode,
        output externalDataIn
    );

endinterface

// File: rtl/serial_memory_loader_uart_rx.sv
// UART byte receiver: 2-flop synchroniser, mid-bit sampling, glitch-rejecting start check.
// byteValid / stopError are one-clk pulses at the stop-bit centre; no backpressure, bytes are never held.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxByte,
    output logic       byteValid,
    output logic       stopError
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rxState_t      rxState;
    logic          rxMeta;
    logic          rxSync;
    logic          rxPrev;
    logic [CW-1:0] clkCnt;
    logic [2:0]    bitIdx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxState   <= RX_IDLE;
            rxMeta    <= 1'b1;
            rxSync    <= 1'b1;
            rxPrev    <= 1'b1;
            clkCnt    <= '0;
            bitIdx    <= '0;
            rxByte    <= '0;
            byteValid <= 1'b0;
            stopError <= 1'b0;
        end else begin
            rxMeta    <= rx;
            rxSync    <= rxMeta;
            rxPrev    <= rxSync;
            byteValid <= 1'b0;
            stopError <= 1'b0;
            case (rxState)
                RX_IDLE: begin
                    if (rxPrev && !rxSync) begin
                        rxState <= RX_START;
                        clkCnt  <= '0;
                    end
                end
                RX_START: begin
                    if (clkCnt == HALF_LAST) begin
                        clkCnt <= '0;
                        bitIdx <= '0;
                        // A line that is high again at mid-start was only a glitch.
                        rxState <= rxSync ? RX_IDLE : RX_DATA;
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clkCnt == BIT_LAST) begin
                        clkCnt <= '0;
                        rxByte <= {rxSync, rxByte[7:1]};
                        if (bitIdx == 3'd7) rxState <= RX_STOP;
                        else                bitIdx  <= bitIdx + 1'b1;
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clkCnt == BIT_LAST) begin
                        clkCnt    <= '0;
                        rxState   <= RX_IDLE;
                        byteValid <= rxSync;
                        stopError <= !rxSync;
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                default: rxState <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/serial_memory_loader.sv
// UART command loader driving the processor memory port: W/R word access, P/G pause control.
// Half-duplex: bytes arriving while a reply is being transmitted are dropped.
module serial_memory_loader
    import mem_mode_pkg::*, loader_pkg::*;
#(
    parameter int CLKS_PER_BIT     = 434,
    parameter int TIMEOUT_CLKS     = 1 << 20,
    parameter int MEM_READ_LATENCY = 1,
    parameter bit BOOT_PAUSED      = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          tx,
    serial_memory_loader_if.master        mem,
    output logic                          busy,
    output logic                          frameError
);

    localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
    localparam int LW = $clog2(MEM_READ_LATENCY + 1) + 1;
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] GAP_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [LW-1:0] WAIT_LAST = LW'(MEM_READ_LATENCY);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic [7:0]    rxByte;
    logic          rxValid;
    logic          rxStopErr;

    loaderState_t  state;
    logic [7:0]    cmdByte;
    logic [1:0]    byteCnt;
    logic [31:0]   addrSr;
    logic [31:0]   dataSr;
    logic          writePhase;
    logic [LW-1:0] waitCnt;
    logic [TW-1:0] gapCnt;
    logic [31:0]   replyBuf;
    logic [2:0]    replyLeft;
    logic [7:0]    txByte;
    logic          txStart;
    logic          txDone;

    logic          txActive;
    logic [9:0]    txShift;
    logic [3:0]    txBitCnt;
    logic [CW-1:0] txClkCnt;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rxByte    (rxByte),
        .byteValid (rxValid),
        .stopError (rxStopErr)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                     <= IDLE;
            cmdByte                   <= '0;
            byteCnt                   <= '0;
            addrSr                    <= '0;
            dataSr                    <= '0;
            writePhase                <= 1'b0;
            waitCnt                   <= '0;
            gapCnt                    <= '0;
            replyBuf                  <= '0;
            replyLeft                 <= '0;
            txByte                    <= '0;
            txStart                   <= 1'b0;
            frameError                <= 1'b0;
            mem.pause                 <= BOOT_PAUSED;
            mem.externalMemoryControl <= BOOT_PAUSED;
            mem.externalAddress       <= '0;
            mem.externalData          <= '0;
            mem.externalReadMode      <= MODE_NONE;
            mem.externalWriteMode     <= MODE_NONE;
        end else begin
            txStart    <= 1'b0;
            frameError <= rxStopErr;

            if (rxValid || !(state == GET_ADDR || state == GET_DATA)) gapCnt <= '0;
            else                                                       gapCnt <= gapCnt + 1'b1;

            case (state)
                IDLE: begin
                    if (rxValid) begin
                        case (rxByte)
                            CMD_W, CMD_R: begin
                                cmdByte <= rxByte;
                                byteCnt <= '0;
                                state   <= GET_ADDR;
                            end
                            CMD_P: begin
                                mem.pause                 <= 1'b1;
                                mem.externalMemoryControl <= 1'b1;
                                replyBuf                  <= {RSP_K, 24'h0};
                                replyLeft                 <= 3'd1;
                                state                     <= SEND;
                            end
                            CMD_G: begin
                                mem.pause                 <= 1'b0;
                                mem.externalMemoryControl <= 1'b0;
                                replyBuf                  <= {RSP_K, 24'h0};
                                replyLeft                 <= 3'd1;
                                state                     <= SEND;
                            end
                            default: ;
                        endcase
                    end
                end
                GET_ADDR: begin
                    if (rxStopErr) begin
                        state <= IDLE;
                    end else if (gapCnt == GAP_LAST) begin
                        state      <= IDLE;
                        frameError <= 1'b1;
                    end else if (rxValid) begin
                        addrSr  <= {addrSr[23:0], rxByte};
                        byteCnt <= byteCnt + 1'b1;
                        if (byteCnt == 2'd3) begin
                            if (cmdByte == CMD_W) begin
                                state <= GET_DATA;
                            end else if (mem.pause) begin
                                mem.externalAddress  <= {addrSr[23:0], rxByte};
                                mem.externalReadMode <= MODE_WORD;
                                waitCnt              <= '0;
                                state                <= READ_WAIT;
                            end else begin
                                replyBuf  <= {RSP_E, 24'h0};
                                replyLeft <= 3'd1;
                                state     <= SEND;
                            end
                        end
                    end
                end
                GET_DATA: begin
                    if (rxStopErr) begin
                        state <= IDLE;
                    end else if (gapCnt == GAP_LAST) begin
                        state      <= IDLE;
                        frameError <= 1'b1;
                    end else if (rxValid) begin
                        dataSr  <= {dataSr[23:0], rxByte};
                        byteCnt <= byteCnt + 1'b1;
                        if (byteCnt == 2'd3) begin
                            if (mem.pause) begin
                                // Address/data settle a full clk before the write strobe.
                                mem.externalAddress <= addrSr;
                                mem.externalData    <= {dataSr[23:0], rxByte};
                                writePhase          <= 1'b0;
                                state               <= WRITE;
                            end else begin
                                replyBuf  <= {RSP_E, 24'h0};
                                replyLeft <= 3'd1;
                                state     <= SEND;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!writePhase) begin
                        mem.externalWriteMode <= MODE_WORD;
                        writePhase            <= 1'b1;
                    end else begin
                        mem.externalWriteMode <= MODE_NONE;
                        replyBuf              <= {RSP_K, 24'h0};
                        replyLeft             <= 3'd1;
                        state                 <= SEND;
                    end
                end
                READ_WAIT: begin
                    if (waitCnt == WAIT_LAST) begin
                        mem.externalReadMode <= MODE_NONE;
                        replyBuf             <= mem.externalDataIn;
                        replyLeft            <= 3'd4;
                        state                <= SEND;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                SEND: begin
                    txByte    <= replyBuf[31:24];
                    replyBuf  <= {replyBuf[23:0], 8'h00};
                    replyLeft <= replyLeft - 1'b1;
                    txStart   <= 1'b1;
                    state     <= SEND_WAIT;
                end
                SEND_WAIT: begin
                    if (txDone) state <= (replyLeft == 3'd0) ? IDLE : SEND;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Frame shifter: bit 0 is always on the line; shifts in idle-high ones behind it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx       <= 1'b1;
            txActive <= 1'b0;
            txShift  <= '1;
            txBitCnt <= '0;
            txClkCnt <= '0;
            txDone   <= 1'b0;
        end else begin
            txDone <= 1'b0;
            if (txStart) begin
                txShift  <= {1'b1, txByte, 1'b0};
                tx       <= 1'b0;
                txActive <= 1'b1;
                txBitCnt <= '0;
                txClkCnt <= '0;
            end else if (txActive) begin
                if (txClkCnt == BIT_LAST) begin
                    txClkCnt <= '0;
                    if (txBitCnt == 4'd9) begin
                        txActive <= 1'b0;
                        txDone   <= 1'b1;
                        tx       <= 1'b1;
                    end else begin
                        txBitCnt <= txBitCnt + 1'b1;
                        tx       <= txShift[1];
                        txShift  <= {1'b1, txShift[9:1]};
                    end
                end else begin
                    txClkCnt <= txClkCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_memory_loader.sv
// Directed bench for serial_memory_loader with a word-memory model and TX/write scoreboards.
module tb_serial_memory_loader;
    import mem_mode_pkg::*;
    import loader_pkg::*;

    localparam int CPB     = 16;
    localparam int TIMEOUT = 2048;
    localparam int LAT     = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic tx;
    logic busy;
    logic frameError;

    serial_memory_loader_if memBus ();

    serial_memory_loader #(
        .CLKS_PER_BIT     (CPB),
        .TIMEOUT_CLKS     (TIMEOUT),
        .MEM_READ_LATENCY (LAT),
        .BOOT_PAUSED      (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .tx         (tx),
        .mem        (memBus),
        .busy       (busy),
        .frameError (frameError)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  expTx [$];
    logic [31:0] expWrAddr [$];
    logic [31:0] expWrData [$];
    logic [31:0] memModel [logic [31:0]];

    int writeCount    = 0;
    int frameErrCount = 0;
    int rxByteCount   = 0;
    int txSeen        = 0;

    // Word memory with one clk of read latency.
    always @(posedge clk) begin
        if (memBus.externalWriteMode == MODE_WORD)
            memModel[memBus.externalAddress] = memBus.externalData;
        if (memBus.externalReadMode == MODE_WORD && memModel.exists(memBus.externalAddress))
            memBus.externalDataIn <= memModel[memBus.externalAddress];
        else
            memBus.externalDataIn <= 32'h0;
    end

    logic       prevTx = 1'b1;
    logic       txMon = 1'b0;
    int         txCnt = 0;
    logic [7:0] txBits = 8'h00;
    logic [2:0] prevWm = MODE_NONE;
    logic [31:0] prevAddr = 32'h0;
    logic [31:0] prevData = 32'h0;
    int         readRun = 0;

    always @(negedge clk) begin
        if (frameError) frameErrCount++;
        if (dut.rxValid) rxByteCount++;

        // TX decoder, aborted by reset
        if (!rst) begin
            txMon = 1'b0;
        end else if (!txMon) begin
            if (prevTx && !tx) begin
                txMon = 1'b1;
                txCnt = 0;
            end
        end else begin
            txCnt++;
            if (txCnt % CPB == CPB / 2) begin
                if (txCnt / CPB >= 1 && txCnt / CPB <= 8) begin
                    txBits[txCnt / CPB - 1] = tx;
                end else if (txCnt / CPB == 9) begin
                    txMon = 1'b0;
                    txSeen++;
                    checks++;
                    if (expTx.size() == 0) begin
                        assert (1'b0) else begin
                            failures++;
                            $error("FAIL tx_unexpected observed=%h expected=none", txBits);
                        end
                    end else begin
                        automatic logic [7:0] e = expTx.pop_front();
                        assert (txBits === e) else begin
                            failures++;
                            $error("FAIL tx_byte observed=%h expected=%h", txBits, e);
                        end
                    end
                end
            end
        end
        prevTx = tx;

        // write strobe checks
        if (memBus.externalWriteMode == MODE_WORD) begin
            writeCount++;
            checks++;
            assert (prevWm !== MODE_WORD) else begin
                failures++;
                $error("FAIL wr_pulse_width observed=multi-clk expected=1clk");
            end
            checks++;
            assert (prevAddr === memBus.externalAddress && prevData === memBus.externalData) else begin
                failures++;
                $error("FAIL wr_setup observed=%h/%h expected=%h/%h", prevAddr, prevData,
                       memBus.externalAddress, memBus.externalData);
            end
            checks++;
            if (expWrAddr.size() == 0) begin
                assert (1'b0) else begin
                    failures++;
                    $error("FAIL wr_unexpected observed=%h expected=none", memBus.externalAddress);
                end
            end else begin
                automatic logic [31:0] ea = expWrAddr.pop_front();
                automatic logic [31:0] ed = expWrData.pop_front();
                assert (memBus.externalAddress === ea && memBus.externalData === ed) else begin
                    failures++;
                    $error("FAIL wr_addr_data observed=%h/%h expected=%h/%h",
                           memBus.externalAddress, memBus.externalData, ea, ed);
                end
            end
        end
        prevWm   = memBus.externalWriteMode;
        prevAddr = memBus.externalAddress;
        prevData = memBus.externalData;

        // read strobe length
        if (memBus.externalReadMode == MODE_WORD) begin
            readRun++;
        end else if (readRun != 0) begin
            checks++;
            assert (readRun == LAT + 1) else begin
                failures++;
                $error("FAIL rd_strobe_len observed=%0d expected=%0d", readRun, LAT + 1);
            end
            readRun = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stopBit;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) sendByte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (expTx.size() != 0 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(expTx.size()), 32'd0);
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, "_tx"},    {31'd0, tx}, 32'd1);
        chk({tag, "_pause"}, {31'd0, memBus.pause}, 32'd1);
        chk({tag, "_emc"},   {31'd0, memBus.externalMemoryControl}, 32'd1);
        chk({tag, "_addr"},  memBus.externalAddress, 32'd0);
        chk({tag, "_data"},  memBus.externalData, 32'd0);
        chk({tag, "_rmode"}, {29'd0, memBus.externalReadMode}, 32'd0);
        chk({tag, "_wmode"}, {29'd0, memBus.externalWriteMode}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_ferr"},  {31'd0, frameError}, 32'd0);
    endtask

    initial begin
        int wc;
        int fe;
        int rb;
        int ts;
        int n;

        repeat (5) @(negedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: word write while paused
        expWrAddr.push_back(32'h0000_0010);
        expWrData.push_back(32'hDEAD_BEEF);
        expTx.push_back(8'h4B);
        sendByte(CMD_W, 1'b1);
        sendWord(32'h0000_0010);
        sendWord(32'hDEAD_BEEF);
        waitDrain("t1_drain");
        chk("t1_writes", 32'(writeCount), 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // 2: word read back, MSB first
        expTx.push_back(8'hDE);
        expTx.push_back(8'hAD);
        expTx.push_back(8'hBE);
        expTx.push_back(8'hEF);
        sendByte(CMD_R, 1'b1);
        sendWord(32'h0000_0010);
        waitDrain("t2_drain");
        chk("t2_rmode", {29'd0, memBus.externalReadMode}, {29'd0, MODE_NONE});
        chk("t2_busy", {31'd0, busy}, 32'd0);

        // 3: go, then a write is refused
        expTx.push_back(8'h4B);
        sendByte(CMD_G, 1'b1);
        waitDrain("t3g_drain");
        chk("t3_pause", {31'd0, memBus.pause}, 32'd0);
        chk("t3_emc", {31'd0, memBus.externalMemoryControl}, 32'd0);
        wc = writeCount;
        expTx.push_back(8'h45);
        sendByte(CMD_W, 1'b1);
        sendWord(32'h0000_0020);
        sendWord(32'h1122_3344);
        waitDrain("t3w_drain");
        chk("t3_nowrite", 32'(writeCount - wc), 32'd0);

        // 4: inter-byte timeout
        wc = writeCount;
        fe = frameErrCount;
        sendByte(CMD_W, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h00, 1'b1);
        repeat (TIMEOUT + 10) @(negedge clk);
        chk("t4_ferr", 32'(frameErrCount - fe), 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_nowrite", 32'(writeCount - wc), 32'd0);
        expTx.push_back(8'h4B);
        sendByte(CMD_P, 1'b1);
        waitDrain("t4p_drain");
        chk("t4_pause", {31'd0, memBus.pause}, 32'd1);

        // 5: bad stop bit on a 'G', then a short glitch
        fe = frameErrCount;
        rb = rxByteCount;
        sendByte(CMD_G, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        chk("t5_stop_ferr", 32'(frameErrCount - fe), 32'd1);
        chk("t5_stop_pause", {31'd0, memBus.pause}, 32'd1);
        chk("t5_stop_nobyte", 32'(rxByteCount - rb), 32'd0);
        fe = frameErrCount;
        @(posedge clk);
        rx = 1'b0;
        repeat (5) @(posedge clk);
        rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("t5_glitch_ferr", 32'(frameErrCount - fe), 32'd0);
        chk("t5_glitch_nobyte", 32'(rxByteCount - rb), 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);

        // 6: reset in the middle of the second reply byte
        expTx.push_back(8'hDE);
        ts = txSeen;
        sendByte(CMD_R, 1'b1);
        sendWord(32'h0000_0010);
        n = 0;
        while (txSeen == ts && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first_byte", 32'(txSeen - ts), 32'd1);
        repeat (4 * CPB) @(negedge clk);
        chk("t6_mid_tx_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        checkResetState("t6_reset");
        expTx.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        wc = writeCount;
        expTx.push_back(8'h4B);
        sendByte(CMD_P, 1'b1);
        waitDrain("t6p_drain");
        chk("t6_pause", {31'd0, memBus.pause}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_nowrite", 32'(writeCount - wc), 32'd0);
        chk("end_wr_pending", 32'(expWrAddr.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
